mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32ima_pkg.sv | 26 ++
 rtl/mem_arb_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32ima_pkg.sv
// Shared types for the memory arbiter: machine word, byte enables,
// arbiter state encoding and the registered memory request payload.
package rv32ima_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [BE_W-1:0] be_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  // Everything the memory side sees, captured at grant time
  typedef struct packed {
    word_t addr;
    word_t wdata;
    be_t   be;
    logic  ren;
    logic  wen;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester/memory bundle for mem_arbiter.
//   arb  : arbiter view (requests in, hits and memory strobes out)
//   imem : instruction fetch requester
//   dmem : data load/store requester
//   mem  : memory device (strobes in, ready/rdata out)
interface mem_arb_if;
  import rv32ima_pkg::*;

  logic  iren;
  word_t iaddr;
  logic  ihit;
  word_t iload;

  logic  dren;
  logic  dwen;
  word_t daddr;
  word_t dstore;
  be_t   dbe;
  logic  dhit;
  word_t dload;

  logic  bus_err;

  logic  mem_ren;
  logic  mem_wen;
  word_t mem_addr;
  word_t mem_wdata;
  be_t   mem_be;
  logic  mem_ready;
  word_t mem_rdata;

  modport arb (
    input  iren, iaddr, dren, dwen, daddr, dstore, dbe, mem_ready, mem_rdata,
    output ihit, iload, dhit, dload, bus_err,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_be
  );

  modport imem (
    output iren, iaddr,
    input  ihit, iload, bus_err
  );

  modport dmem (
    output dren, dwen, daddr, dstore, dbe,
    input  dhit, dload, bus_err
  );

  modport mem (
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction fetch and a data
// requester. Data has priority, but a fetch is forced through after
// STARVE_LIMIT data grants taken while it waited. A busy access that
// sees no mem_ready for TIMEOUT cycles is aborted with bus_err.
// Ports:
//   clk  : clock, rising edge
//   nrst : asynchronous active-low reset
//   bus  : mem_arb_if.arb (requests, hits/loads, memory strobes)
module mem_arbiter
  import rv32ima_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   nrst,
  mem_arb_if.arb bus
);

  localparam int unsigned STARVE_LIMIT = 3;
  localparam int unsigned STARVE_W     = 2;
  localparam int unsigned WAIT_W       = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  mem_req_t            req_q, req_d;
  logic                done;
  logic                timeout;
  logic                d_req;

  assign d_req = bus.dren | bus.dwen;

  // State, counters and memory-side request registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      starve_q <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      req_q    <= req_d;
    end
  end

  // Arbitration, completion and timeout
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    req_d    = req_q;
    done     = 1'b0;
    timeout  = 1'b0;

    unique case (state_q)
      IDLE: begin
        wait_d = '0;
        // Starved fetch wins over a data request
        if (d_req && !(bus.iren && (starve_q == STARVE_W'(STARVE_LIMIT)))) begin
          req_d.addr  = bus.daddr;
          req_d.wdata = bus.dstore;
          req_d.be    = bus.dbe;
          req_d.wen   = bus.dwen;
          req_d.ren   = bus.dren & ~bus.dwen;
          if (bus.iren) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          state_d = DBUSY;
        end else if (bus.iren) begin
          req_d.addr  = bus.iaddr;
          req_d.wdata = '0;
          req_d.be    = '1;
          req_d.wen   = 1'b0;
          req_d.ren   = 1'b1;
          starve_d    = '0;
          state_d     = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (bus.mem_ready) begin
          done = 1'b1;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          done    = 1'b1;
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (done) begin
          req_d.ren = 1'b0;
          req_d.wen = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hits complete in the same cycle as mem_ready; loads are zero otherwise
  assign bus.ihit    = done && (state_q == IBUSY);
  assign bus.dhit    = done && (state_q == DBUSY);
  assign bus.bus_err = timeout;
  assign bus.iload   = (bus.ihit && !timeout) ? bus.mem_rdata : '0;
  assign bus.dload   = (bus.dhit && !timeout) ? bus.mem_rdata : '0;

  assign bus.mem_ren   = req_q.ren;
  assign bus.mem_wen   = req_q.wen;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.mem_be    = req_q.be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data priority, starvation,
// timeout, mid-transaction reset, dropped request, idle mem_ready.
module tb_mem_arbiter;
  import rv32ima_pkg::*;

  logic clk;
  logic nrst;
  int   vectors;
  int   miscompares;

  mem_arb_if bus ();

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.ihit, bus.dhit, bus.bus_err, bus.iload, bus.dload} !== '0) begin
      $display("FAIL reset_hits: got %0b%0b%0b iload=%h dload=%h, want all 0",
               bus.ihit, bus.dhit, bus.bus_err, bus.iload, bus.dload);
      miscompares++;
    end
    vectors++;
    if ({bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
      $display("FAIL reset_mem: ren=%b wen=%b addr=%h wdata=%h be=%h, want all 0",
               bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_be);
      miscompares++;
    end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    bus.iren  = 1'b1;
    bus.iaddr = 32'h100;
    #2;
    vectors++;
    if (bus.mem_ren !== 1'b0) begin
      $display("FAIL fetch_pregrant: mem_ren=%b want 0", bus.mem_ren);
      miscompares++;
    end
    step();
    vectors++;
    if ({bus.mem_ren, bus.mem_wen, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      $display("FAIL fetch_grant: ren=%b wen=%b be=%h addr=%h want 1 0 f 00000100",
               bus.mem_ren, bus.mem_wen, bus.mem_be, bus.mem_addr);
      miscompares++;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00500093;
    #2;
    vectors++;
    if ({bus.ihit, bus.dhit, bus.bus_err, bus.iload, bus.dload} !== {3'b100, 32'h00500093, 32'h0}) begin
      $display("FAIL fetch_hit: ihit=%b dhit=%b err=%b iload=%h dload=%h want 1 0 0 00500093 0",
               bus.ihit, bus.dhit, bus.bus_err, bus.iload, bus.dload);
      miscompares++;
    end
    step();
    bus.iren      = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    vectors++;
    if ({bus.mem_ren, bus.ihit, bus.iload} !== '0) begin
      $display("FAIL fetch_done: ren=%b ihit=%b iload=%h want 0 0 0",
               bus.mem_ren, bus.ihit, bus.iload);
      miscompares++;
    end
  endtask

  task automatic test_data_priority();
    bus.iren   = 1'b1;
    bus.iaddr  = 32'h200;
    bus.dwen   = 1'b1;
    bus.daddr  = 32'h2000;
    bus.dstore = 32'hDEADBEEF;
    bus.dbe    = 4'b0011;
    step();
    vectors++;
    if ({bus.mem_ren, bus.mem_wen, bus.mem_be, bus.mem_addr, bus.mem_wdata} !==
        {1'b0, 1'b1, 4'h3, 32'h2000, 32'hDEADBEEF}) begin
      $display("FAIL prio_data_grant: ren=%b wen=%b be=%h addr=%h wdata=%h want 0 1 3 00002000 deadbeef",
               bus.mem_ren, bus.mem_wen, bus.mem_be, bus.mem_addr, bus.mem_wdata);
      miscompares++;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h12345678;
    #2;
    vectors++;
    if ({bus.dhit, bus.ihit, bus.dload} !== {2'b10, 32'h12345678}) begin
      $display("FAIL prio_dhit: dhit=%b ihit=%b dload=%h want 1 0 12345678",
               bus.dhit, bus.ihit, bus.dload);
      miscompares++;
    end
    step();
    bus.dwen      = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    vectors++;
    if ({bus.mem_ren, bus.mem_wen} !== 2'b00) begin
      $display("FAIL prio_idle_gap: ren=%b wen=%b want 0 0", bus.mem_ren, bus.mem_wen);
      miscompares++;
    end
    step();
    vectors++;
    if ({bus.mem_ren, bus.mem_wen, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h200}) begin
      $display("FAIL prio_fetch_grant: ren=%b wen=%b be=%h addr=%h want 1 0 f 00000200",
               bus.mem_ren, bus.mem_wen, bus.mem_be, bus.mem_addr);
      miscompares++;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000A001;
    #2;
    vectors++;
    if ({bus.ihit, bus.iload} !== {1'b1, 32'h0000A001}) begin
      $display("FAIL prio_ihit: ihit=%b iload=%h want 1 0000a001", bus.ihit, bus.iload);
      miscompares++;
    end
    step();
    bus.iren      = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp_data [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   data_n;
    word_t exp_addr;
    data_n    = 0;
    bus.iren  = 1'b1;
    bus.iaddr = 32'h300;
    bus.dbe   = 4'hF;
    for (int g = 0; g < 5; g++) begin
      bus.dren  = (data_n < 4);
      bus.daddr = 32'h4000 + 32'(data_n * 4);
      exp_addr  = exp_data[g] ? 32'h4000 + 32'(data_n * 4) : 32'h300;
      step();
      vectors++;
      if ({bus.mem_ren, bus.mem_addr} !== {1'b1, exp_addr}) begin
        $display("FAIL starve_grant%0d: ren=%b addr=%h want 1 %h", g, bus.mem_ren, bus.mem_addr, exp_addr);
        miscompares++;
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'(g);
      #2;
      vectors++;
      if ({bus.dhit, bus.ihit} !== {exp_data[g], ~exp_data[g]}) begin
        $display("FAIL starve_hit%0d: dhit=%b ihit=%b want %b %b", g, bus.dhit, bus.ihit,
                 exp_data[g], ~exp_data[g]);
        miscompares++;
      end
      step();
      bus.mem_ready = 1'b0;
      if (exp_data[g]) data_n++;
    end
    bus.dren = 1'b0;
    bus.iren = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    early         = 0;
    bus.dren      = 1'b1;
    bus.daddr     = 32'h5000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hFFFFFFFF;
    step();
    for (int c = 1; c < 16; c++) begin
      #2;
      if (bus.dhit || bus.bus_err) early++;
      step();
    end
    vectors++;
    if (early !== 0) begin
      $display("FAIL timeout_early: %0d early pulses, want 0", early);
      miscompares++;
    end
    #2;
    vectors++;
    if ({bus.dhit, bus.bus_err, bus.ihit, bus.dload} !== {3'b110, 32'h0}) begin
      $display("FAIL timeout_pulse: dhit=%b err=%b ihit=%b dload=%h want 1 1 0 0",
               bus.dhit, bus.bus_err, bus.ihit, bus.dload);
      miscompares++;
    end
    step();
    bus.dren = 1'b0;
    #2;
    vectors++;
    if ({bus.mem_ren, bus.dhit, bus.bus_err} !== 3'b000 || dut.state_q !== IDLE) begin
      $display("FAIL timeout_idle: ren=%b dhit=%b err=%b state=%0d want 0 0 0 IDLE",
               bus.mem_ren, bus.dhit, bus.bus_err, dut.state_q);
      miscompares++;
    end
    bus.mem_rdata = 32'h0;
  endtask

  task automatic test_reset_mid();
    bus.dren  = 1'b1;
    bus.daddr = 32'h6000;
    step();
    vectors++;
    if (bus.mem_ren !== 1'b1) begin
      $display("FAIL rstmid_grant: mem_ren=%b want 1", bus.mem_ren);
      miscompares++;
    end
    #2;
    nrst          = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    vectors++;
    if ({bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_be, bus.dhit, bus.ihit, bus.bus_err, bus.dload} !== '0
        || dut.state_q !== IDLE) begin
      $display("FAIL rstmid_outputs: ren=%b addr=%h be=%h dhit=%b dload=%h state=%0d want all 0 IDLE",
               bus.mem_ren, bus.mem_addr, bus.mem_be, bus.dhit, bus.dload, dut.state_q);
      miscompares++;
    end
    step();
    bus.mem_ready = 1'b0;
    bus.iren      = 1'b1;
    bus.iaddr     = 32'h700;
    nrst          = 1'b1;
    step();
    vectors++;
    if ({bus.mem_ren, bus.mem_be, bus.mem_addr} !== {1'b1, 4'hF, 32'h6000}) begin
      $display("FAIL rstmid_regrant: ren=%b be=%h addr=%h want 1 f 00006000",
               bus.mem_ren, bus.mem_be, bus.mem_addr);
      miscompares++;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    #2;
    vectors++;
    if ({bus.dhit, bus.dload} !== {1'b1, 32'hCAFEF00D}) begin
      $display("FAIL rstmid_dhit: dhit=%b dload=%h want 1 cafef00d", bus.dhit, bus.dload);
      miscompares++;
    end
    step();
    bus.dren      = 1'b0;
    bus.iren      = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_drop();
    bus.dren  = 1'b1;
    bus.daddr = 32'h7000;
    step();
    bus.dren = 1'b0;
    step();
    vectors++;
    if ({bus.mem_ren, bus.mem_addr, bus.dhit} !== {1'b1, 32'h7000, 1'b0}) begin
      $display("FAIL drop_hold: ren=%b addr=%h dhit=%b want 1 00007000 0",
               bus.mem_ren, bus.mem_addr, bus.dhit);
      miscompares++;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000ABCD;
    #2;
    vectors++;
    if ({bus.dhit, bus.dload} !== {1'b1, 32'h0000ABCD}) begin
      $display("FAIL drop_dhit: dhit=%b dload=%h want 1 0000abcd", bus.dhit, bus.dload);
      miscompares++;
    end
    step();
    bus.mem_ready = 1'b0;
    vectors++;
    if (bus.mem_ren !== 1'b0) begin
      $display("FAIL drop_done: mem_ren=%b want 0", bus.mem_ren);
      miscompares++;
    end
  endtask

  task automatic test_idle_ready();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h55AA55AA;
    #2;
    vectors++;
    if ({bus.ihit, bus.dhit, bus.iload, bus.dload} !== '0) begin
      $display("FAIL idle_ready_hit: ihit=%b dhit=%b iload=%h dload=%h want 0",
               bus.ihit, bus.dhit, bus.iload, bus.dload);
      miscompares++;
    end
    step();
    vectors++;
    if (bus.mem_ren !== 1'b0 || dut.state_q !== IDLE) begin
      $display("FAIL idle_ready_state: ren=%b state=%0d want 0 IDLE", bus.mem_ren, dut.state_q);
      miscompares++;
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    nrst          = 1'b0;
    bus.iren      = 1'b0;
    bus.iaddr     = '0;
    bus.dren      = 1'b0;
    bus.dwen      = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.dbe       = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    test_reset();
    test_fetch();
    test_data_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_drop();
    test_idle_ready();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
